// File: rtl/spi_ctrl_pkg.sv
// Shared register map and FSM state type for the spi_ctrl SPI master.
package spi_ctrl_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_ctrl_if.sv
// Register bus of spi_ctrl: select, write strobe, index, write data, read data.
interface spi_ctrl_if;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport slave  (input  cs, we, addr, data_in, output data_out);
  modport master (output cs, we, addr, data_in, input  data_out);
endinterface

// File: rtl/spi_ctrl.sv
// Register-mapped SPI master, mode 0, MSB first, 8-bit frames.
// Optional interrupt output and enable bit (CTRL bit1) with SPI_CTRL_IRQ_EN.
module spi_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned DEFAULT_DIV = 124
) (
  input  logic       clk_50,
  input  logic       resb,
  spi_ctrl_if.slave  bus,
  output logic       sd_cs,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso
`ifdef SPI_CTRL_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam logic [7:0] DIV_RST = 8'(DEFAULT_DIV);

  spi_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] hp_cnt_q, hp_cnt_d;
  logic [7:0] div_q, div_d;
  logic [7:0] div_act_q, div_act_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_q, rx_d;
  logic       done_q, done_d;
  logic       ovr_q, ovr_d;
  logic       cs_lvl_q, cs_lvl_d;
  logic       ctrl_ie;
  logic       busy;
  logic       wr, rd, done_set;

  assign wr   = bus.cs & bus.we;
  assign rd   = bus.cs & ~bus.we;
  assign busy = (state_q != ST_IDLE);

`ifdef SPI_CTRL_IRQ_EN
  logic ie_q, ie_d;

  always_ff @(posedge clk_50 or negedge resb) begin
    if (!resb) ie_q <= 1'b0;
    else       ie_q <= ie_d;
  end

  always_comb begin
    ie_d = ie_q;
    if (wr && bus.addr == REG_CTRL) ie_d = bus.data_in[1];
  end

  assign ctrl_ie = ie_q;
  assign irq     = done_q & ie_q;
`else
  assign ctrl_ie = 1'b0;
`endif

  always_ff @(posedge clk_50 or negedge resb) begin
    if (!resb) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      hp_cnt_q  <= '0;
      div_q     <= DIV_RST;
      div_act_q <= DIV_RST;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_q      <= '0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      cs_lvl_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      hp_cnt_q  <= hp_cnt_d;
      div_q     <= div_d;
      div_act_q <= div_act_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_q      <= rx_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      cs_lvl_q  <= cs_lvl_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    hp_cnt_d  = hp_cnt_q;
    div_d     = div_q;
    div_act_d = div_act_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_d      = rx_q;
    done_d    = done_q;
    ovr_d     = ovr_q;
    cs_lvl_d  = cs_lvl_q;
    done_set  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (wr && bus.addr == REG_DATA) begin
          tx_d      = bus.data_in;
          div_act_d = div_q;
          hp_cnt_d  = '0;
          bit_cnt_d = '0;
          state_d   = ST_LOW;
        end
      end
      ST_LOW: begin
        if (hp_cnt_q == div_act_q) begin
          hp_cnt_d = '0;
          rx_sh_d  = {rx_sh_q[6:0], spi_miso};
          state_d  = ST_HIGH;
        end else begin
          hp_cnt_d = hp_cnt_q + 8'd1;
        end
      end
      ST_HIGH: begin
        if (hp_cnt_q == div_act_q) begin
          hp_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            // RX becomes visible only once the whole frame is in
            rx_d     = rx_sh_q;
            done_set = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = {tx_q[6:0], 1'b0};
            state_d   = ST_LOW;
          end
        end else begin
          hp_cnt_d = hp_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr && bus.addr == REG_DATA && busy) ovr_d = 1'b1;
    if (wr && bus.addr == REG_DIV)          div_d = bus.data_in;
    if (wr && bus.addr == REG_CTRL)         cs_lvl_d = bus.data_in[0];

    // A completion in the same cycle as the clearing read keeps done set
    if (rd && bus.addr == REG_DATA) begin
      done_d = 1'b0;
      ovr_d  = 1'b0;
    end
    if (done_set) done_d = 1'b1;
  end

  always_comb begin
    bus.data_out = '0;
    unique case (bus.addr)
      REG_DATA:   bus.data_out = rx_q;
      REG_STATUS: bus.data_out = {5'b0, ovr_q, done_q, busy};
      REG_DIV:    bus.data_out = div_q;
      REG_CTRL:   bus.data_out = {6'b0, ctrl_ie, cs_lvl_q};
      default:    bus.data_out = '0;
    endcase
  end

  assign sd_cs    = cs_lvl_q;
  assign spi_clk  = (state_q == ST_HIGH);
  assign spi_mosi = (state_q == ST_IDLE) ? 1'b1 : tx_q[7];

endmodule

// File: tb/tb_spi_ctrl.sv
// Directed self-checking bench for spi_ctrl; define SPI_CTRL_IRQ_EN to cover irq.
module tb_spi_ctrl;
  import spi_ctrl_pkg::*;

  logic clk_50 = 1'b0;
  logic resb   = 1'b0;
  logic sd_cs, spi_clk, spi_mosi, spi_miso;
  logic loop_en  = 1'b0;
  logic miso_tie = 1'b0;
`ifdef SPI_CTRL_IRQ_EN
  logic irq;
`endif

  int n_vec = 0;
  int n_err = 0;

  spi_ctrl_if bus_if ();

  spi_ctrl #(.DEFAULT_DIV(124)) dut (
    .clk_50  (clk_50),
    .resb    (resb),
    .bus     (bus_if),
    .sd_cs   (sd_cs),
    .spi_clk (spi_clk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
`ifdef SPI_CTRL_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  assign spi_miso = loop_en ? spi_mosi : miso_tie;

  always #5 clk_50 = ~clk_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk_50);
    bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.data_in = d;
    @(negedge clk_50);
    bus_if.cs = 1'b0; bus_if.we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk_50);
    bus_if.cs = 1'b1; bus_if.we = 1'b0; bus_if.addr = a;
    #1 d = bus_if.data_out;
    @(negedge clk_50);
    bus_if.cs = 1'b0;
  endtask

  // Starts a frame, polls STATUS every cycle, optionally injects one write at cycle inj_k.
  task automatic run_xfer(input string tag, input logic [7:0] tx, input int div,
                          input int inj_k, input logic [1:0] inj_a, input logic [7:0] inj_d);
    logic [7:0] mosi_bits;
    logic prev_clk;
    int rises, first_rise, last_rise, min_sp, max_sp, busy_cyc, end_k, limit;
    mosi_bits = '0; prev_clk = 1'b0;
    rises = 0; first_rise = -1; last_rise = -1; min_sp = 100000; max_sp = 0;
    busy_cyc = 0; end_k = -1; limit = 16 * (div + 1) + 20;
    bus_write(REG_DATA, tx);
    for (int k = 1; k <= limit; k++) begin
      if (k > 1) @(negedge clk_50);
      if (spi_clk && !prev_clk) begin
        mosi_bits = {mosi_bits[6:0], spi_mosi};
        if (first_rise < 0) first_rise = k;
        else begin
          if (k - last_rise < min_sp) min_sp = k - last_rise;
          if (k - last_rise > max_sp) max_sp = k - last_rise;
        end
        last_rise = k;
        rises++;
      end
      prev_clk = spi_clk;
      bus_if.cs = 1'b1; bus_if.we = 1'b0; bus_if.addr = REG_STATUS;
      #1;
      if (bus_if.data_out[0]) busy_cyc++;
      else begin
        end_k = k;
        chk({tag, "_idle_clk"}, 32'(spi_clk), 32'd0);
        chk({tag, "_idle_mosi"}, 32'(spi_mosi), 32'd1);
        break;
      end
      if (k == inj_k) begin
        bus_if.we = 1'b1; bus_if.addr = inj_a; bus_if.data_in = inj_d;
      end
    end
    bus_if.cs = 1'b0; bus_if.we = 1'b0;
    chk({tag, "_end_cycle"}, end_k, 16 * (div + 1) + 1);
    chk({tag, "_busy_cycles"}, busy_cyc, 16 * (div + 1));
    chk({tag, "_rises"}, rises, 8);
    chk({tag, "_first_rise"}, first_rise, div + 2);
    chk({tag, "_min_spacing"}, min_sp, 2 * (div + 1));
    chk({tag, "_max_spacing"}, max_sp, 2 * (div + 1));
    chk({tag, "_mosi"}, 32'(mosi_bits), 32'(tx));
  endtask

  initial begin
    logic [7:0] rd;
    int rises;
    logic prev_clk;
    bus_if.cs = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.data_in = '0;

    // Reset state
    repeat (3) @(negedge clk_50);
    chk("rst_spi_clk", 32'(spi_clk), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd1);
    chk("rst_sd_cs", 32'(sd_cs), 32'd1);
    resb = 1'b1;
    bus_read(REG_STATUS, rd); chk("rst_status", 32'(rd), 32'h00);
    bus_read(REG_DIV, rd);    chk("rst_div", 32'(rd), 32'd124);
    bus_read(REG_CTRL, rd);   chk("rst_ctrl", 32'(rd), 32'h01);
    bus_read(REG_DATA, rd);   chk("rst_data", 32'(rd), 32'h00);

    // CTRL drives sd_cs; bit1 only exists with the interrupt option
    bus_write(REG_CTRL, 8'h03);
    bus_read(REG_CTRL, rd);
`ifdef SPI_CTRL_IRQ_EN
    chk("ctrl_rd_03", 32'(rd), 32'h03);
`else
    chk("ctrl_rd_03", 32'(rd), 32'h01);
`endif
    bus_write(REG_CTRL, 8'h00);
    chk("sd_cs_low", 32'(sd_cs), 32'd0);

    // DIV=1, 0xA5 loopback
    bus_write(REG_DIV, 8'd1);
    loop_en = 1'b1;
    run_xfer("a5", 8'hA5, 1, -1, REG_DATA, 8'h00);
    bus_read(REG_STATUS, rd); chk("a5_status", 32'(rd), 32'h02);
    bus_read(REG_DATA, rd);   chk("a5_rx", 32'(rd), 32'hA5);
    bus_read(REG_STATUS, rd); chk("a5_status_clr", 32'(rd), 32'h00);

    // DIV=0, 0x3C, miso tied high
    bus_write(REG_DIV, 8'd0);
    loop_en = 1'b0; miso_tie = 1'b1;
    run_xfer("3c", 8'h3C, 0, -1, REG_DATA, 8'h00);
    bus_read(REG_DATA, rd);   chk("3c_rx", 32'(rd), 32'hFF);

    // DATA write while busy is dropped and flags overrun
    bus_write(REG_DIV, 8'd1);
    loop_en = 1'b1;
    run_xfer("ovr", 8'h22, 1, 10, REG_DATA, 8'h11);
    bus_read(REG_STATUS, rd); chk("ovr_status", 32'(rd), 32'h06);
    bus_read(REG_DATA, rd);   chk("ovr_rx", 32'(rd), 32'h22);
    bus_read(REG_STATUS, rd); chk("ovr_status_clr", 32'(rd), 32'h00);

    // DIV write while busy takes effect only on the next frame
    run_xfer("divlate", 8'h5A, 1, 6, REG_DIV, 8'd0);
    bus_read(REG_DATA, rd);   chk("divlate_rx", 32'(rd), 32'h5A);
    run_xfer("divnext", 8'hC3, 0, -1, REG_DATA, 8'h00);
    bus_read(REG_DATA, rd);   chk("divnext_rx", 32'(rd), 32'hC3);

    // Asynchronous reset mid-frame
    bus_write(REG_DIV, 8'd1);
    bus_write(REG_DATA, 8'hF0);
    rises = 0; prev_clk = 1'b0;
    for (int k = 0; k < 100 && rises < 3; k++) begin
      if (k > 0) @(negedge clk_50);
      if (spi_clk && !prev_clk) rises++;
      prev_clk = spi_clk;
    end
    chk("abort_rises", rises, 3);
    @(negedge clk_50);
    #2 resb = 1'b0;
    #1;
    chk("abort_spi_clk", 32'(spi_clk), 32'd0);
    chk("abort_mosi", 32'(spi_mosi), 32'd1);
    chk("abort_sd_cs", 32'(sd_cs), 32'd1);
    @(negedge clk_50);
    resb = 1'b1;
    bus_read(REG_STATUS, rd); chk("abort_status", 32'(rd), 32'h00);
    bus_read(REG_DIV, rd);    chk("abort_div", 32'(rd), 32'd124);
    bus_read(REG_DATA, rd);   chk("abort_rx", 32'(rd), 32'h00);
    run_xfer("0f", 8'h0F, 124, -1, REG_DATA, 8'h00);
    bus_read(REG_DATA, rd);   chk("0f_rx", 32'(rd), 32'h0F);

`ifdef SPI_CTRL_IRQ_EN
    bus_write(REG_CTRL, 8'h03);
    bus_write(REG_DIV, 8'd0);
    chk("irq_idle", 32'(irq), 32'd0);
    run_xfer("irq", 8'h81, 0, -1, REG_DATA, 8'h00);
    chk("irq_set", 32'(irq), 32'd1);
    bus_read(REG_DATA, rd);
    chk("irq_clr", 32'(irq), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
